// File: rtl/rs_rename_table_pkg.sv
// Shared sizing constants for the rename table; module parameters default from these.
package rs_rename_table_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned REG_INDEX = 5;
    localparam int unsigned FU_INDEX  = 4;
    localparam int unsigned NUM_READ  = 3;
    localparam int unsigned READY     = 0;

endpackage

// File: rtl/rs_rename_table_if.sv
// Issue/CDB/read bundle between the issue stage (master) and the rename table (slave).
interface rs_rename_table_if #(
    parameter int unsigned WORD_SIZE = rs_rename_table_pkg::WORD_SIZE,
    parameter int unsigned REG_INDEX = rs_rename_table_pkg::REG_INDEX,
    parameter int unsigned FU_INDEX  = rs_rename_table_pkg::FU_INDEX,
    parameter int unsigned NUM_READ  = rs_rename_table_pkg::NUM_READ
) ();

    logic [NUM_READ*REG_INDEX-1:0] rd_idx;
    logic [NUM_READ*WORD_SIZE-1:0] rd_value;
    logic [NUM_READ*FU_INDEX-1:0]  rd_status;
    logic                          iss_en;
    logic [REG_INDEX-1:0]          iss_reg;
    logic [FU_INDEX-1:0]           iss_tag;
    logic                          cdb_valid;
    logic [FU_INDEX-1:0]           cdb_tag;
    logic [WORD_SIZE-1:0]          cdb_data;
    logic                          flush;
    logic [REG_INDEX:0]            busy_count;

    modport master (
        output rd_idx, iss_en, iss_reg, iss_tag, cdb_valid, cdb_tag, cdb_data, flush,
        input  rd_value, rd_status, busy_count
    );

    modport slave (
        input  rd_idx, iss_en, iss_reg, iss_tag, cdb_valid, cdb_tag, cdb_data, flush,
        output rd_value, rd_status, busy_count
    );

endinterface

// File: rtl/rs_rename_table_entry.sv
// One architectural register: stored value plus producer tag, with CDB capture and rename update.
module rs_rename_table_entry #(
    parameter int unsigned WORD_SIZE = rs_rename_table_pkg::WORD_SIZE,
    parameter int unsigned FU_INDEX  = rs_rename_table_pkg::FU_INDEX,
    parameter int unsigned READY     = rs_rename_table_pkg::READY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_hit_i,
    input  logic [FU_INDEX-1:0]  iss_tag_i,
    input  logic                 cdb_en_i,
    input  logic [FU_INDEX-1:0]  cdb_tag_i,
    input  logic [WORD_SIZE-1:0] cdb_data_i,
    input  logic                 flush_i,
    output logic [WORD_SIZE-1:0] value_o,
    output logic [FU_INDEX-1:0]  tag_o,
    output logic                 busy_nxt_c_o
);

    logic [WORD_SIZE-1:0] value_q, value_d;
    logic [FU_INDEX-1:0]  tag_q, tag_d;
    logic                 cdb_match_c;

    // cdb_en_i already excludes a READY broadcast tag, so a match implies a pending producer.
    assign cdb_match_c = cdb_en_i && (tag_q == cdb_tag_i);

    // Flush beats issue, issue beats CDB retirement: the newer producer owns the tag.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (cdb_match_c) begin
            value_d = cdb_data_i;
            tag_d   = FU_INDEX'(READY);
        end
        if (iss_hit_i) begin
            tag_d = iss_tag_i;
        end
        if (flush_i) begin
            tag_d = FU_INDEX'(READY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            tag_q   <= FU_INDEX'(READY);
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    assign value_o      = value_q;
    assign tag_o        = tag_q;
    assign busy_nxt_c_o = (tag_d != FU_INDEX'(READY));

endmodule

// File: rtl/rs_rename_table.sv
// Register-status table: per-register value/producer tag, N read ports with CDB bypass, busy count.
module rs_rename_table #(
    parameter int unsigned WORD_SIZE = rs_rename_table_pkg::WORD_SIZE,
    parameter int unsigned REG_INDEX = rs_rename_table_pkg::REG_INDEX,
    parameter int unsigned FU_INDEX  = rs_rename_table_pkg::FU_INDEX,
    parameter int unsigned NUM_READ  = rs_rename_table_pkg::NUM_READ,
    parameter int unsigned READY     = rs_rename_table_pkg::READY
) (
    input  logic              clk,
    input  logic              reset,
    rs_rename_table_if.slave  bus
);

    localparam int unsigned NREG  = 2 ** REG_INDEX;
    localparam int unsigned CNT_W = REG_INDEX + 1;

    logic [WORD_SIZE-1:0] value_c [NREG];
    logic [FU_INDEX-1:0]  tag_c   [NREG];
    logic [NREG-1:0]      busy_nxt_c;
    logic                 cdb_en_c;
    logic                 iss_en_c;
    logic [CNT_W-1:0]     busy_count_q, busy_count_d;

    assign cdb_en_c = bus.cdb_valid && (bus.cdb_tag != FU_INDEX'(READY));
    assign iss_en_c = bus.iss_en && !bus.flush && (bus.iss_tag != FU_INDEX'(READY));

    for (genvar r = 0; r < NREG; r++) begin : g_entry
        rs_rename_table_entry #(
            .WORD_SIZE (WORD_SIZE),
            .FU_INDEX  (FU_INDEX),
            .READY     (READY)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .iss_hit_i    (iss_en_c && (bus.iss_reg == REG_INDEX'(r))),
            .iss_tag_i    (bus.iss_tag),
            .cdb_en_i     (cdb_en_c),
            .cdb_tag_i    (bus.cdb_tag),
            .cdb_data_i   (bus.cdb_data),
            .flush_i      (bus.flush),
            .value_o      (value_c[r]),
            .tag_o        (tag_c[r]),
            .busy_nxt_c_o (busy_nxt_c[r])
        );
    end

    // Read muxes; a completing producer is forwarded in its broadcast cycle.
    always_comb begin
        logic [REG_INDEX-1:0] ridx;
        ridx          = '0;
        bus.rd_value  = '0;
        bus.rd_status = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            ridx = bus.rd_idx[k*REG_INDEX +: REG_INDEX];
            if (bus.cdb_valid && (tag_c[ridx] == bus.cdb_tag) && (tag_c[ridx] != FU_INDEX'(READY))) begin
                bus.rd_value[k*WORD_SIZE +: WORD_SIZE] = bus.cdb_data;
                bus.rd_status[k*FU_INDEX +: FU_INDEX]  = FU_INDEX'(READY);
            end else begin
                bus.rd_value[k*WORD_SIZE +: WORD_SIZE] = value_c[ridx];
                bus.rd_status[k*FU_INDEX +: FU_INDEX]  = tag_c[ridx];
            end
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            busy_count_d = busy_count_d + CNT_W'(busy_nxt_c[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_count_q <= '0;
        end else begin
            busy_count_q <= busy_count_d;
        end
    end

    assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_rs_rename_table.sv
// Directed bench for rs_rename_table: issue, CDB capture/bypass, flush and async reset.
module tb_rs_rename_table;

    localparam int unsigned W  = 32;
    localparam int unsigned RI = 5;
    localparam int unsigned FI = 4;
    localparam int unsigned NR = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    rs_rename_table_if #(.WORD_SIZE(W), .REG_INDEX(RI), .FU_INDEX(FI), .NUM_READ(NR)) bus ();

    rs_rename_table #(
        .WORD_SIZE (W),
        .REG_INDEX (RI),
        .FU_INDEX  (FI),
        .NUM_READ  (NR),
        .READY     (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [RI-1:0] a, input logic [RI-1:0] b, input logic [RI-1:0] c);
        bus.rd_idx = {c, b, a};
    endtask

    task automatic chk_port(input string nm, input int k, input logic [31:0] ev, input logic [FI-1:0] es);
        chk({nm, "_val"}, 32'(bus.rd_value[k*W +: W]), ev);
        chk({nm, "_st"}, 32'(bus.rd_status[k*FI +: FI]), 32'(es));
    endtask

    task automatic chk_busy(input string nm, input int exp);
        chk(nm, 32'(bus.busy_count), 32'(exp));
    endtask

    task automatic issue(input logic [RI-1:0] r, input logic [FI-1:0] t);
        bus.iss_en  = 1'b1;
        bus.iss_reg = r;
        bus.iss_tag = t;
    endtask

    task automatic cdb(input logic [FI-1:0] t, input logic [W-1:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
    endtask

    task automatic idle();
        bus.iss_en    = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.rd_idx   = '0;
        bus.iss_reg  = '0;
        bus.iss_tag  = '0;
        bus.cdb_tag  = '0;
        bus.cdb_data = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        set_rd(5'd0, 5'd5, 5'd31);
        #1;
        chk_port("rst_r0", 0, 32'h0, 4'd0);
        chk_port("rst_r5", 1, 32'h0, 4'd0);
        chk_port("rst_r31", 2, 32'h0, 4'd0);
        chk_busy("rst_busy", 0);

        // Issue r3 tag 2, then retire via CDB with bypass
        issue(5'd3, 4'd2);
        tick();
        idle();
        set_rd(5'd3, 5'd3, 5'd0);
        #1;
        chk_port("iss_r3", 0, 32'h0, 4'd2);
        chk_busy("iss_busy", 1);
        cdb(4'd2, 32'hDEADBEEF);
        #1;
        chk_port("byp_r3", 0, 32'hDEADBEEF, 4'd0);
        chk_port("byp_dup", 1, 32'hDEADBEEF, 4'd0);
        chk_port("byp_r0", 2, 32'h0, 4'd0);
        tick();
        idle();
        #1;
        chk_port("wb_r3", 0, 32'hDEADBEEF, 4'd0);
        chk_busy("wb_busy", 0);

        // Two registers waiting on the same producer
        issue(5'd4, 4'd5);
        tick();
        issue(5'd7, 4'd5);
        tick();
        idle();
        set_rd(5'd4, 5'd7, 5'd3);
        #1;
        chk_port("multi_r4_pend", 0, 32'h0, 4'd5);
        chk_port("multi_r7_pend", 1, 32'h0, 4'd5);
        chk_busy("multi_busy2", 2);
        cdb(4'd5, 32'h11);
        tick();
        idle();
        #1;
        chk_port("multi_r4", 0, 32'h11, 4'd0);
        chk_port("multi_r7", 1, 32'h11, 4'd0);
        chk_busy("multi_busy0", 0);

        // Issue and CDB collide on r6: value from CDB, tag from issue
        issue(5'd6, 4'd3);
        tick();
        issue(5'd6, 4'd9);
        cdb(4'd3, 32'h22);
        tick();
        idle();
        set_rd(5'd6, 5'd0, 5'd0);
        #1;
        chk_port("coll_r6", 0, 32'h22, 4'd9);
        chk_busy("coll_busy", 1);

        // Flush with simultaneous issue and CDB
        issue(5'd1, 4'd4);
        tick();
        issue(5'd2, 4'd6);
        tick();
        idle();
        #1;
        chk_busy("pre_flush_busy", 3);
        issue(5'd8, 4'd7);
        cdb(4'd4, 32'h33);
        bus.flush = 1'b1;
        tick();
        idle();
        set_rd(5'd1, 5'd2, 5'd8);
        #1;
        chk_port("fl_r1", 0, 32'h33, 4'd0);
        chk_port("fl_r2", 1, 32'h0, 4'd0);
        chk_port("fl_r8", 2, 32'h0, 4'd0);
        chk_busy("fl_busy", 0);
        set_rd(5'd6, 5'd0, 5'd0);
        #1;
        chk_port("fl_r6", 0, 32'h22, 4'd0);

        // Illegal CDB tag READY and issue with READY tag are ignored
        cdb(4'd0, 32'h55);
        issue(5'd9, 4'd0);
        set_rd(5'd0, 5'd9, 5'd6);
        #1;
        chk_port("ill_byp_r0", 0, 32'h0, 4'd0);
        tick();
        idle();
        #1;
        chk_port("ill_r0", 0, 32'h0, 4'd0);
        chk_port("ill_r9", 1, 32'h0, 4'd0);
        chk_port("ill_r6", 2, 32'h22, 4'd0);
        chk_busy("ill_busy", 0);

        // Async reset mid-cycle with three tags pending
        issue(5'd10, 4'd1);
        tick();
        issue(5'd11, 4'd2);
        tick();
        issue(5'd12, 4'd3);
        tick();
        idle();
        set_rd(5'd10, 5'd1, 5'd3);
        #1;
        chk_busy("ar_pre_busy", 3);
        chk_port("ar_pre_r10", 0, 32'h0, 4'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_busy("ar_busy", 0);
        chk_port("ar_r10", 0, 32'h0, 4'd0);
        chk_port("ar_r1", 1, 32'h0, 4'd0);
        chk_port("ar_r3", 2, 32'h0, 4'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
